// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-sequencer bundle: ID/EX/MEM hazard sources in, pipeline enables,
// flush/hold strobes and performance counters out.
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_branch_taken;
    logic              mem_dmem_req;
    logic              dmem_ready;
    logic              cnt_clr;

    logic              pc_write;
    logic              if_id_write;
    logic              ctrl_stall;
    logic              if_id_flush;
    logic              ex_mem_flush;
    logic              pipe_hold;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
               mem_branch_taken, mem_dmem_req, dmem_ready, cnt_clr,
        input  pc_write, if_id_write, ctrl_stall, if_id_flush, ex_mem_flush,
               pipe_hold, mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
               mem_branch_taken, mem_dmem_req, dmem_ready, cnt_clr,
        output pc_write, if_id_write, ctrl_stall, if_id_flush, ex_mem_flush,
               pipe_hold, mem_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flushes, dmem wait
// freezes with a sticky timeout, and saturating hazard performance counters.
module hazard_stall_ctrl #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                reset,
    hazard_stall_ctrl_if.slave bus
);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [WCNT_W-1:0] wait_cnt_nxt_s;
    logic              mem_timeout_r;
    logic              timeout_set_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_nxt_s;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_nxt_s;

    logic              rs1_hit_s;
    logic              rs2_hit_s;
    logic              load_use_s;
    logic              mem_wait_s;
    logic              stall_inc_s;
    logic              flush_inc_s;

    logic              dec_pc_write_s;
    logic              dec_if_id_write_s;
    logic              dec_ctrl_stall_s;
    logic              dec_if_id_flush_s;
    logic              dec_ex_mem_flush_s;
    logic              dec_pipe_hold_s;

    logic              pc_write_s;
    logic              if_id_write_s;
    logic              ctrl_stall_s;
    logic              if_id_flush_s;
    logic              ex_mem_flush_s;
    logic              pipe_hold_s;

    // Hazard sources; a load into x0 never creates a dependency
    always_comb begin
        rs1_hit_s  = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd);
        rs2_hit_s  = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd);
        load_use_s = bus.ex_memread && (bus.ex_rd != {REG_AW{1'b0}})
                     && (rs1_hit_s || rs2_hit_s);
        mem_wait_s = bus.mem_dmem_req && !bus.dmem_ready;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt_s        = state_r;
        wait_cnt_nxt_s     = wait_cnt_r;
        timeout_set_s      = 1'b0;
        stall_inc_s        = 1'b0;
        flush_inc_s        = 1'b0;
        dec_pc_write_s     = 1'b1;
        dec_if_id_write_s  = 1'b1;
        dec_ctrl_stall_s   = 1'b0;
        dec_if_id_flush_s  = 1'b0;
        dec_ex_mem_flush_s = 1'b0;
        dec_pipe_hold_s    = 1'b0;

        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_wait_s) begin
                    dec_pc_write_s    = 1'b0;
                    dec_if_id_write_s = 1'b0;
                    dec_pipe_hold_s   = 1'b1;
                    stall_inc_s       = 1'b1;
                    if (state_r == ST_RUN) begin
                        state_nxt_s    = ST_MEM_WAIT;
                        wait_cnt_nxt_s = WCNT_W'(1);
                    end else if (wait_cnt_r >= WCNT_W'(TIMEOUT - 1)) begin
                        // This cycle is the TIMEOUT-th consecutive wait
                        state_nxt_s    = ST_ERROR;
                        wait_cnt_nxt_s = WCNT_W'(TIMEOUT);
                        timeout_set_s  = 1'b1;
                    end else begin
                        state_nxt_s    = ST_MEM_WAIT;
                        wait_cnt_nxt_s = wait_cnt_r + WCNT_W'(1);
                    end
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {WCNT_W{1'b0}};
                    if (bus.mem_branch_taken) begin
                        dec_if_id_flush_s  = 1'b1;
                        dec_ctrl_stall_s   = 1'b1;
                        dec_ex_mem_flush_s = 1'b1;
                        flush_inc_s        = 1'b1;
                    end else if (load_use_s) begin
                        dec_pc_write_s    = 1'b0;
                        dec_if_id_write_s = 1'b0;
                        dec_ctrl_stall_s  = 1'b1;
                        stall_inc_s       = 1'b1;
                    end else begin
                        dec_pc_write_s    = 1'b1;
                        dec_if_id_write_s = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                dec_pc_write_s    = 1'b0;
                dec_if_id_write_s = 1'b0;
                dec_pipe_hold_s   = 1'b1;
                state_nxt_s       = ST_ERROR;
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = {WCNT_W{1'b0}};
            end
        endcase
    end

    // Outputs read as a free-running pipeline while reset is asserted
    always_comb begin
        if (reset) begin
            pc_write_s     = 1'b1;
            if_id_write_s  = 1'b1;
            ctrl_stall_s   = 1'b0;
            if_id_flush_s  = 1'b0;
            ex_mem_flush_s = 1'b0;
            pipe_hold_s    = 1'b0;
        end else begin
            pc_write_s     = dec_pc_write_s;
            if_id_write_s  = dec_if_id_write_s;
            ctrl_stall_s   = dec_ctrl_stall_s;
            if_id_flush_s  = dec_if_id_flush_s;
            ex_mem_flush_s = dec_ex_mem_flush_s;
            pipe_hold_s    = dec_pipe_hold_s;
        end
    end

    // Saturating counters; clear wins over any increment
    always_comb begin
        if (bus.cnt_clr) begin
            stall_cnt_nxt_s = {CNT_W{1'b0}};
            flush_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_nxt_s = stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_nxt_s = stall_cnt_r;
            end
            if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_nxt_s = flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_nxt_s = flush_cnt_r;
            end
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= {WCNT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_r | timeout_set_s;
        end
    end

    // Performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= stall_cnt_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

    assign bus.pc_write     = pc_write_s;
    assign bus.if_id_write  = if_id_write_s;
    assign bus.ctrl_stall   = ctrl_stall_s;
    assign bus.if_id_flush  = if_id_flush_s;
    assign bus.ex_mem_flush = ex_mem_flush_s;
    assign bus.pipe_hold    = pipe_hold_s;
    assign bus.mem_timeout  = mem_timeout_r;
    assign bus.stall_cycles = stall_cnt_r;
    assign bus.flush_events = flush_cnt_r;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes model expectations,
// an independent monitor pops and compares every cycle.
module tb_hazard_stall_ctrl;
    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    hazard_stall_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_stall_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic pc_write;
        logic if_id_write;
        logic ctrl_stall;
        logic if_id_flush;
        logic ex_mem_flush;
        logic pipe_hold;
        logic mem_timeout;
        int   stall_cycles;
        int   flush_events;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // reference model: consecutive-wait length, error latch, plain counters
    int m_wait  = 0;
    bit m_err   = 1'b0;
    bit m_to    = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit rst_v, input int rs1, input int rs2, input bit u1,
                        input bit u2, input bit memrd, input int rd, input bit br,
                        input bit req, input bit rdy, input bit clr);
        exp_t e;
        bit   lu;
        bit   mw;
        bit   was_err;
        @(negedge clk);
        #1;
        reset                = rst_v;
        bus.id_rs1           = REG_AW'(rs1);
        bus.id_rs2           = REG_AW'(rs2);
        bus.id_use_rs1       = u1;
        bus.id_use_rs2       = u2;
        bus.ex_memread       = memrd;
        bus.ex_rd            = REG_AW'(rd);
        bus.mem_branch_taken = br;
        bus.mem_dmem_req     = req;
        bus.dmem_ready       = rdy;
        bus.cnt_clr          = clr;

        e.pc_write = 1'b1; e.if_id_write = 1'b1; e.ctrl_stall = 1'b0;
        e.if_id_flush = 1'b0; e.ex_mem_flush = 1'b0; e.pipe_hold = 1'b0;
        if (rst_v) begin
            m_wait = 0; m_err = 1'b0; m_to = 1'b0; m_stall = 0; m_flush = 0;
            e.mem_timeout = 1'b0; e.stall_cycles = 0; e.flush_events = 0;
        end else begin
            e.mem_timeout  = m_to;
            e.stall_cycles = m_stall;
            e.flush_events = m_flush;
            lu = memrd && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            mw = req && !rdy;
            was_err = m_err;
            if (m_err || mw) begin
                e.pc_write = 1'b0; e.if_id_write = 1'b0; e.pipe_hold = 1'b1;
                if (!m_err) begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) begin
                        m_err = 1'b1;
                        m_to  = 1'b1;
                    end
                end
            end else begin
                m_wait = 0;
                if (br) begin
                    e.if_id_flush = 1'b1; e.ctrl_stall = 1'b1; e.ex_mem_flush = 1'b1;
                    if (m_flush < CMAX) m_flush++;
                end else if (lu) begin
                    e.pc_write = 1'b0; e.if_id_write = 1'b0; e.ctrl_stall = 1'b1;
                end
            end
            if (!was_err && !e.pc_write && m_stall < CMAX) m_stall++;
            if (clr) begin
                m_stall = 0;
                m_flush = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_step(input bit allow_rst);
        step(allow_rst && ($urandom_range(0, 49) == 0),
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 7) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1),
             $urandom_range(0, 19) == 0);
    endtask

    // driver
    initial begin
        reset = 1'b1;
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_memread = 1'b0; bus.ex_rd = '0; bus.mem_branch_taken = 1'b0;
        bus.mem_dmem_req = 1'b0; bus.dmem_ready = 1'b0; bus.cnt_clr = 1'b0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5, 5, 1, 1, 1, 5, 1, 1, 0, 0);
        idle();
        step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0);   // load-use
        idle();
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);   // x0 destination
        step(0, 0, 7, 0, 0, 1, 7, 0, 0, 0, 0);   // rs2 matches but unused
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0);   // branch with load-use
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle();
        repeat (TIMEOUT) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (10) rand_step(0);
        step(1, 3, 3, 1, 1, 1, 3, 1, 1, 0, 0);   // async reset out of ERROR
        idle();
        repeat (20) step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0);
        step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 1);   // clear while stalling
        repeat (3) step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        repeat (800) rand_step(1);
        idle();
        @(negedge clk);
        #1;
        done = 1'b1;
    end

    // monitor
    initial begin
        exp_t e;
        while (!(done && exp_q.size() == 0)) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0) begin
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
                end
            end else begin
                e = exp_q.pop_front();
                chk("pc_write",     int'(bus.pc_write),     int'(e.pc_write));
                chk("if_id_write",  int'(bus.if_id_write),  int'(e.if_id_write));
                chk("ctrl_stall",   int'(bus.ctrl_stall),   int'(e.ctrl_stall));
                chk("if_id_flush",  int'(bus.if_id_flush),  int'(e.if_id_flush));
                chk("ex_mem_flush", int'(bus.ex_mem_flush), int'(e.ex_mem_flush));
                chk("pipe_hold",    int'(bus.pipe_hold),    int'(e.pipe_hold));
                chk("mem_timeout",  int'(bus.mem_timeout),  int'(e.mem_timeout));
                chk("stall_cycles", int'(bus.stall_cycles), e.stall_cycles);
                chk("flush_events", int'(bus.flush_events), e.flush_events);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
